// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding, lane width.
// Also holds the legality check used when an access is accepted.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int BE_W = 4;

  // Unsigned loads have no store counterpart; halfwords need even, words 4-byte alignment.
  function automatic logic access_legal(input logic st, input logic [2:0] f3, input logic [1:0] lo);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~lo[0];
      F3_W:    ok = (lo == 2'b00);
      F3_BU:   ok = ~st;
      F3_HU:   ok = ~st & ~lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request port: registered request fields out, ready/read data back.
// mem_rdata is only meaningful in a cycle where mem_ready is high.
interface mem_access_unit_if;
  import mem_access_pkg::*;

  logic            mem_req;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic [BE_W-1:0] mem_be;
  logic            mem_ready;
  logic [31:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_extend.sv
// Combinational lane select and sign/zero extension of a loaded memory word.
// Halfword lanes use addr[1] only; alignment was already enforced upstream.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] ext_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = mem_rdata[7:0];
    case (addr)
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      2'd3:    lane_b = mem_rdata[31:24];
      default: lane_b = mem_rdata[7:0];
    endcase
    lane_h = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (funct3)
      F3_B:    ext_data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   ext_data = {24'd0, lane_b};
      F3_H:    ext_data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   ext_data = {16'd0, lane_h};
      default: ext_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: IDLE -> REQ (held until mem_ready or timeout) -> DONE pulse.
// Min latency start->done is 2 cycles, +1 per wait cycle; illegal accesses finish in 1.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_store,
  input  logic [2:0]         funct3,
  input  logic [31:0]        addr,
  input  logic [31:0]        store_data,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [31:0]        read_data,
  mem_access_unit_if.master  mem
);
  import mem_access_pkg::*;

  localparam logic [31:0] TMO = 32'(TIMEOUT);

  logic [1:0]      state;
  logic [2:0]      f3_r;
  logic [1:0]      lane_r;
  logic            fault_r;
  logic [31:0]     wait_cnt;
  logic            legal;
  logic [BE_W-1:0] be_n;
  logic [31:0]     wdata_n;
  logic [31:0]     ext;

  assign legal = access_legal(is_store, funct3, addr[1:0]);

  // Narrow stores replicate their data across every lane so the byte enables alone pick the target.
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        be_n    = 4'b0001 << addr[1:0];
        wdata_n = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_n    = 4'b0011 << {addr[1], 1'b0};
        wdata_n = {2{store_data[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = store_data;
      end
    endcase
  end

  load_extend u_load_extend (
    .mem_rdata (mem.mem_rdata),
    .addr      (lane_r),
    .funct3    (f3_r),
    .ext_data  (ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      f3_r          <= 3'd0;
      lane_r        <= 2'd0;
      fault_r       <= 1'b0;
      wait_cnt      <= 32'd0;
      read_data     <= 32'd0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 32'd0;
      mem.mem_wdata <= 32'd0;
      mem.mem_be    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            f3_r     <= funct3;
            lane_r   <= addr[1:0];
            wait_cnt <= 32'd0;
            if (legal) begin
              state         <= S_REQ;
              fault_r       <= 1'b0;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= is_store;
              mem.mem_addr  <= {addr[31:2], 2'b00};
              mem.mem_be    <= be_n;
              mem.mem_wdata <= wdata_n;
            end else begin
              state   <= S_DONE;
              fault_r <= 1'b1;
            end
          end
        end
        S_REQ: begin
          // A ready arriving in the very cycle the wait budget runs out still completes the access.
          if (mem.mem_ready) begin
            mem.mem_req <= 1'b0;
            state       <= S_DONE;
            if (!mem.mem_we) begin
              read_data <= ext;
            end
          end else if ((TMO != 32'd0) && (wait_cnt + 32'd1 == TMO)) begin
            mem.mem_req <= 1'b0;
            fault_r     <= 1'b1;
            state       <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign fault = done & fault_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit against a behavioural load/store model.
// Stimulus pushes expected outcomes; a negedge monitor checks requests and completions.
module tb_mem_access_unit;

  localparam int TMO = 4;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    int          lat;
    int          n_req;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mbe;
    int          start_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] read_data;

  mem_access_unit_if mem_if ();

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .read_data  (read_data),
    .mem        (mem_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        exp_q[$];
  logic [31:0] model_rd = 32'd0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Reference behaviour of one access, taken straight from the access rules.
  function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [31:0] rd, input int dly);
    exp_t        e;
    int          sz;
    int          nbytes;
    bit          ok;
    logic [31:0] v;
    sz     = int'(f3[1:0]);
    nbytes = 1 << sz;
    ok     = st ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (ok && (int'(a[1:0]) % nbytes) != 0) ok = 0;
    e.n_req = !ok ? 0 : ((dly < TMO) ? dly + 1 : TMO);
    e.fault = !ok || (dly >= TMO);
    e.lat   = e.n_req + 1;
    if (ok && !st && dly < TMO) begin
      v = rd >> (8 * int'(a[1:0]));
      if (sz == 0) v = f3[2] ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
      else if (sz == 1) v = f3[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      else v = rd;
      model_rd = v;
    end
    e.rdata  = model_rd;
    e.we     = st;
    e.maddr  = a - 32'(a[1:0]);
    e.mbe    = (sz == 0) ? 4'(1 << int'(a[1:0])) : (sz == 1) ? 4'(3 << int'(a[1:0])) : 4'hF;
    e.mwdata = (sz == 0) ? 32'(sd[7:0]) * 32'h0101_0101 :
               (sz == 1) ? 32'(sd[15:0]) * 32'h0001_0001 : sd;
    e.start_cyc = 0;
    return e;
  endfunction

  // Called just after a rising edge with the unit idle; returns in IDLE.
  task automatic op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] sd, input logic [31:0] rd, input int dly, input bit poke);
    exp_t e;
    e = model(st, f3, a, sd, rd, dly);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    @(posedge clk); #1;
    e.start_cyc = cyc;
    exp_q.push_back(e);
    start = 1'b0; is_store = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; store_data = $urandom;
    for (int k = 0; k < e.n_req; k++) begin
      mem_if.mem_ready = (k == dly);
      mem_if.mem_rdata = (k == dly) ? rd : $urandom;
      start = poke && (k == 1);
      @(posedge clk); #1;
    end
    start = poke;
    mem_if.mem_ready = 1'($urandom);
    mem_if.mem_rdata = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      mem_if.mem_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    mem_if.mem_ready = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    int   req_cycles;
    req_cycles = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_cycles = 0;
        continue;
      end
      chk("busy", 32'(busy), 32'(exp_q.size() != 0));
      if (mem_if.mem_req) begin
        chk("req_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          chk("mem_addr", mem_if.mem_addr, e.maddr);
          chk("mem_be", 32'(mem_if.mem_be), 32'(e.mbe));
          chk("mem_we", 32'(mem_if.mem_we), 32'(e.we));
          if (e.we) chk("mem_wdata", mem_if.mem_wdata, e.mwdata);
          req_cycles++;
        end
      end
      if (done) begin
        chk("done_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("fault", 32'(fault), 32'(e.fault));
          chk("read_data", read_data, e.rdata);
          chk("latency", 32'(cyc - e.start_cyc + 1), 32'(e.lat));
          chk("req_cycles", 32'(req_cycles), 32'(e.n_req));
        end
        req_cycles = 0;
      end
    end
  end

  initial begin : stimulus
    exp_t e;
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
    mem_if.mem_ready = 1'b0; mem_if.mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_if.mem_we), 32'd0);
    chk("rst_mem_addr", mem_if.mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_if.mem_wdata, 32'd0);
    chk("rst_mem_be", 32'(mem_if.mem_be), 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    op(1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 1'b0);
    op(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h8011_2233, 0, 1'b0);
    op(1'b0, 3'b100, 32'h0000_0103, 32'd0, 32'h8011_2233, 1, 1'b0);
    op(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h1111_1111, 3, 1'b1);
    op(1'b0, 3'b010, 32'h0000_0101, 32'd0, 32'h5555_5555, 0, 1'b1);
    op(1'b1, 3'b100, 32'h0000_0300, 32'h1234_5678, 32'd0, 0, 1'b0);
    op(1'b0, 3'b010, 32'h0000_0010, 32'd0, 32'hFFFF_FFFF, 9, 1'b1);
    op(1'b1, 3'b000, 32'h0000_0401, 32'h0000_00A5, 32'd0, 2, 1'b0);

    // Reset during the second REQ cycle of a load that would otherwise time out.
    e = model(1'b0, 3'b010, 32'h0000_0040, 32'd0, 32'h1234_5678, 9);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0040;
    @(posedge clk); #1;
    e.start_cyc = cyc;
    exp_q.push_back(e);
    start = 1'b0; mem_if.mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_mem_req", 32'(mem_if.mem_req), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_read_data", read_data, 32'd0);
    exp_q.delete();
    model_rd = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      st = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0)
        a[1:0] = (f3[1:0] == 2'd0) ? a[1:0] : (f3[1:0] == 2'd1) ? {a[1], 1'b0} : 2'b00;
      op(st, f3, a, $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 4) == 0);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store unit between the datapath and data memory. It takes the effective address from the ALU, rs2 store data and funct3 from the controller, then runs a req/ready transaction on the data-memory port. For loads it lane-aligns and sign/zero-extends the returned word into a memory data register. That register's `read_data` output is the load input of the writeback select mux.

## Interface
- `TIMEOUT`, default 255: max cycles in REQ waiting for `mem_ready`; 0 disables the timeout.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request from the controller; sampled only in IDLE.
- `is_store` in 1: 1 = store, 0 = load.
- `funct3` in 3: loads LB=000, LH=001, LW=010, LBU=100, LHU=101; stores SB=000, SH=001, SW=010.
- `addr` in 32: effective byte address.
- `store_data` in 32: rs2 value.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: valid only with `done`; set on misalignment, illegal funct3 or timeout.
- `read_data` out 32: extended load result (MDR); holds its value until the next successful load.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32, `mem_wdata` out 32, `mem_be` out 4: memory request; all registered.
- `mem_ready` in 1: memory accepts/completes the access.
- `mem_rdata` in 32: load data, valid when `mem_ready` is high.

## Operation
- States: IDLE, REQ, DONE.
- **IDLE**
  - On `start`, capture `addr`, `funct3`, `is_store` and `store_data`.
  - Check legality: H needs `addr[0]`=0; W needs `addr[1:0]`=0; loads allow only 000/001/010/100/101; stores allow only 000/001/010.
  - Illegal access goes to DONE with `fault`=1. No memory request is issued and `read_data` is unchanged.
  - Legal access goes to REQ.
- **Request signals in REQ**
  - `mem_addr` = {addr[31:2],2'b00}.
  - `mem_we` = `is_store`.
  - `mem_be`: B = 4'b0001<<addr[1:0]; H = 4'b0011<<{addr[1],1'b0}; W = 4'b1111. Loads use the same enables.
  - `mem_wdata`: SB replicates the byte in all 4 lanes; SH replicates the halfword in both halves; SW passes `store_data` through.
- **REQ**
  - `mem_req`=1; all request signals stay stable until the handshake.
  - Handshake completes on the edge where `mem_req` && `mem_ready`.
  - Loads: on that edge, select the lane by `addr[1:0]`, extend (signed for B/H, zero for BU/HU) and write `read_data`.
  - Either way, go to DONE.
  - Wait counter increments each REQ cycle without ready. If it reaches `TIMEOUT` (nonzero): drop `mem_req`, go to DONE with `fault`=1, leave `read_data` unchanged.
- **DONE**
  - `done`=1 for exactly one cycle, then return to IDLE.
  - `fault` reflects the completed access.
- **Simultaneous events**
  - `start` while `busy` is ignored; no queuing.
  - `start` in the DONE cycle is ignored.
  - `mem_ready` outside REQ is ignored.
- **Reset mid-operation**
  - All outputs drop immediately (async): `mem_req`=0, state=IDLE.
  - No `done` is produced for the aborted access; the memory side must tolerate the abandoned request.

## Timing
- Reset values: state IDLE; `busy`, `done`, `fault`, `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `read_data` = 0; `mem_be` = 4'b0000; wait counter = 0.
- `start` sampled at edge t: `mem_req` is high during cycle t+1.
- If `mem_ready` is high in cycle t+1: `done` and the new `read_data` are visible in cycle t+2. This is the minimum latency of 2 cycles.
- Each wait cycle adds 1 cycle of latency.
- Fault path (illegal access): `done`+`fault` in cycle t+1.
- Timeout path: `done`+`fault` in the cycle after REQ has lasted `TIMEOUT` cycles.
- `read_data` is stable from the `done` cycle until the next load completes. The controller may register writeback in any later cycle.

## Structure
- Shared package `mem_access_pkg` holds:
  - the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state encoding (2-bit localparams S_IDLE, S_REQ, S_DONE);
  - the byte-enable width constant.
- Sub-module `load_extend`: combinational; inputs `mem_rdata`, `addr[1:0]`, `funct3`; output is the 32-bit extended value.
- Store lane replication and byte-enable generation stay inline in `mem_access_unit`.

## Test plan
- LW at 0x100, memory returns 0xDEADBEEF with `mem_ready` in the first REQ cycle → `read_data`=0xDEADBEEF and `done` 2 cycles after `start`, `fault`=0.
- LB at 0x103, `mem_rdata`=0x80112233 → `mem_be`=4'b1000, `read_data`=0xFFFFFF80; LBU at the same address → `read_data`=0x00000080.
- SH at 0x202, `store_data`=0x0000ABCD, `mem_ready` delayed 3 cycles → request signals stable for 4 REQ cycles: `mem_addr`=0x200, `mem_be`=4'b1100, `mem_wdata`=0xABCDABCD, `mem_we`=1; `done` 5 cycles after `start`, `read_data` unchanged.
- LW at 0x101 → no `mem_req`; `done`+`fault` 1 cycle after `start`; `read_data` keeps its prior value. Also covers store with funct3=100.
- `TIMEOUT`=4, `mem_ready` never asserted → `mem_req` high for 4 cycles, then `done`+`fault`; second `start` pulsed during REQ is ignored.
- `rst` asserted in the 2nd REQ cycle of a load → `mem_req`, `busy` = 0 immediately; no `done`; `read_data`=0; next `start` behaves normally.
